dmem_bridge: RTL
================

# dmem_bridge

Data-memory bridge between the core's data port and the data SRAM. Decodes every core data request, forwards SRAM-region accesses unchanged to `SRamTop`, and serves a small peripheral register window (GPIO output, free-running timer with compare interrupt) locally. Enforces one outstanding request and returns exactly one response per accepted request on the core's response channel. The GPIO register drives the top-level `io_pin`.

## Interface
- `PERIPH_BASE`, 32'h4000_0000, base of peripheral window
- `PERIPH_MASK`, 32'hFFFF_F000, address bits compared against `PERIPH_BASE`; a match selects peripheral, else SRAM
- `clock` in 1, single clock
- `reset` in 1, asynchronous, active-high
- `io_core_req_valid` in 1, request strobe (one cycle per request)
- `io_core_req_addr` in 32, byte address
- `io_core_req_wdata` in 32, write data
- `io_core_req_be` in 4, active byte lanes
- `io_core_req_we` in 1, 1 = write
- `io_core_rsp_valid` out 1, response strobe
- `io_core_rsp_rdata` out 32, read data (0 for writes)
- `io_sram_req_valid`/`addr`/`wdata`/`be`/`we` out 1/32/32/4/1, forwarded request
- `io_sram_rsp_valid` in 1, SRAM response strobe
- `io_sram_rsp_rdata` in 32, SRAM read data
- `io_gpio_out` out 32, GPIO_OUT register
- `io_timer_irq` out 1, timer interrupt level

## Operation
- FSM: IDLE, WAIT_SRAM, PERIPH_RSP.
- IDLE + req_valid, SRAM region: drive `io_sram_req_*` combinationally in the same cycle, go WAIT_SRAM.
- IDLE + req_valid, peripheral region: perform register access that cycle, go PERIPH_RSP.
- WAIT_SRAM: `io_core_rsp_valid = io_sram_rsp_valid`, rdata passed through; on sram_rsp_valid return to IDLE. A new request in that same cycle is not accepted.
- PERIPH_RSP: rsp_valid = 1 for one cycle with registered rdata, return to IDLE.
- req_valid in WAIT_SRAM/PERIPH_RSP: dropped, not forwarded; sets sticky ERR.drop.
- SRAM responses arriving in IDLE/PERIPH_RSP: ignored.
- Register map (offset, word-aligned; addr[1:0] ignored):
  - 0x00 GPIO_OUT RW, byte-lane writes per `be`.
  - 0x10 MTIME RO, 32-bit counter, +1 per cycle when CTRL.en, wraps 0xFFFF_FFFF to 0.
  - 0x14 MTIMECMP RW, byte-lane writes.
  - 0x18 CTRL: bit0 en RW, bit1 pending W1C, bit2 irq_en RW.
  - 0x1C ERR: bit0 drop, W1C.
  - Other offsets: read 0, writes ignored, response still returned.
- pending sets when en and MTIME == MTIMECMP; set and W1C in same cycle: set wins.
- `io_timer_irq` = pending & irq_en.

## Timing
- Reset: FSM IDLE; all outputs 0; GPIO_OUT, MTIME, CTRL, ERR = 0; MTIMECMP = 0xFFFF_FFFF.
- SRAM path latency = SRAM latency + 0; bridge adds no register stage.
- Peripheral latency: rsp_valid exactly 1 cycle after req_valid.
- Peripheral write effect visible on `io_gpio_out` the cycle after req_valid.
- Peripheral read of MTIME returns value present in the request cycle.
- Reset asserted mid-transaction: FSM to IDLE immediately, pending response discarded, no response issued after release.

## Configuration
- `DMEM_BRIDGE_TIMER_EN` defined: timer registers and `io_timer_irq` as above.
- Undefined: offsets 0x10-0x18 behave as unmapped (read 0), no counter logic, `io_timer_irq` tied 0.

## Structure
- `dmem_bridge_pkg`: FSM state enum, register offset constants, CTRL bit indices, MTIMECMP reset value.
- Sub-module `dmem_timer`: MTIME counter, MTIMECMP, CTRL, pending/irq logic; instantiated only under `DMEM_BRIDGE_TIMER_EN`.

## Test plan
- SRAM read 0x0000_0100, SRAM rsp 2 cycles later with 0xDEAD_BEEF -> core rsp_valid that same cycle, rdata 0xDEAD_BEEF, FSM back to IDLE.
- Write 0x4000_0000 data 0x1234_5678 be 4'b0101 over GPIO 0 -> io_gpio_out 0x0034_0078 next cycle; rsp_valid 1 cycle after req.
- CTRL=0x5, MTIMECMP=20 -> pending and io_timer_irq rise when MTIME==20; W1C bit1 clears irq; coincident set+clear keeps pending=1.
- Second req_valid while WAIT_SRAM -> not forwarded, ERR reads 0x1, one core response total.
- Read 0x4000_0040 -> rdata 0, rsp_valid after 1 cycle; reset during WAIT_SRAM -> no core response after reset release.
- Build without `DMEM_BRIDGE_TIMER_EN` -> MTIME reads 0, io_timer_irq stays 0.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared FSM state, peripheral register map and byte-lane merge helper
package dmem_bridge_pkg;
  localparam logic [31:0] PERIPH_BASE   = 32'h4000_0000;
  localparam logic [31:0] PERIPH_MASK   = 32'hFFFF_F000;
  localparam logic [31:0] MTIMECMP_RST  = 32'hFFFF_FFFF;
  localparam logic [11:0] OFF_GPIO      = 12'h000;
  localparam logic [11:0] OFF_MTIME     = 12'h010;
  localparam logic [11:0] OFF_MTIMECMP  = 12'h014;
  localparam logic [11:0] OFF_CTRL      = 12'h018;
  localparam logic [11:0] OFF_ERR       = 12'h01C;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_PEND   = 1;
  localparam int CTRL_IRQ_EN = 2;
  typedef enum logic [1:0] {IDLE, WAIT_SRAM, PERIPH_RSP} state_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: free-running MTIME, MTIMECMP compare, CTRL register and interrupt level
module dmem_timer
  import dmem_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wr,
  input  logic [11:0] off,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] mtime,
  output logic [31:0] mtimecmp,
  output logic [2:0]  ctrl,
  output logic        irq
);
  logic ctrl_wr;
  assign ctrl_wr = wr && off == OFF_CTRL && be[0];
  assign irq = ctrl[CTRL_PEND] & ctrl[CTRL_IRQ_EN];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      ctrl     <= '0;
    end else begin
      if (ctrl[CTRL_EN]) mtime <= mtime + 32'd1;
      if (wr && off == OFF_MTIMECMP) mtimecmp <= be_merge(mtimecmp, wdata, be);
      if (ctrl_wr) begin
        ctrl[CTRL_EN]     <= wdata[CTRL_EN];
        ctrl[CTRL_IRQ_EN] <= wdata[CTRL_IRQ_EN];
      end
      // a compare hit in the same cycle as a W1C keeps pending set
      ctrl[CTRL_PEND] <= (ctrl[CTRL_EN] && mtime == mtimecmp) |
                         (ctrl[CTRL_PEND] & ~(ctrl_wr & wdata[CTRL_PEND]));
    end
  end
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: core data port to SRAM bridge with local GPIO/timer register window
// Timer registers and io_timer_irq exist only when DMEM_BRIDGE_TIMER_EN is defined.
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_core_req_valid,
  input  logic [31:0] io_core_req_addr,
  input  logic [31:0] io_core_req_wdata,
  input  logic [3:0]  io_core_req_be,
  input  logic        io_core_req_we,
  output logic        io_core_rsp_valid,
  output logic [31:0] io_core_rsp_rdata,
  output logic        io_sram_req_valid,
  output logic [31:0] io_sram_req_addr,
  output logic [31:0] io_sram_req_wdata,
  output logic [3:0]  io_sram_req_be,
  output logic        io_sram_req_we,
  input  logic        io_sram_rsp_valid,
  input  logic [31:0] io_sram_rsp_rdata,
  output logic [31:0] io_gpio_out,
  output logic        io_timer_irq
);
  state_t      state;
  logic [31:0] rdata_q, rd_val;
  logic        err_drop, wr_q, hit, sram_go, per_wr, drop;
  logic [11:0] off;
  logic [31:0] mtime, mtimecmp;
  logic [2:0]  ctrl;
  assign hit     = (io_core_req_addr & PERIPH_MASK) == PERIPH_BASE;
  assign off     = {io_core_req_addr[11:2], 2'b00};
  assign sram_go = io_core_req_valid & state == IDLE & ~hit & ~reset;
  assign per_wr  = io_core_req_valid & state == IDLE & hit & io_core_req_we;
  assign drop    = io_core_req_valid & state != IDLE;
  assign io_sram_req_valid = sram_go;
  assign io_sram_req_addr  = sram_go ? io_core_req_addr : '0;
  assign io_sram_req_wdata = sram_go ? io_core_req_wdata : '0;
  assign io_sram_req_be    = sram_go ? io_core_req_be : '0;
  assign io_sram_req_we    = sram_go & io_core_req_we;
  assign io_core_rsp_valid = (state == WAIT_SRAM & io_sram_rsp_valid) | state == PERIPH_RSP;
  assign io_core_rsp_rdata = (state == WAIT_SRAM & io_sram_rsp_valid & ~wr_q) ? io_sram_rsp_rdata :
                             state == PERIPH_RSP ? rdata_q : '0;
`ifdef DMEM_BRIDGE_TIMER_EN
  dmem_timer u_timer (
    .clock(clock), .reset(reset), .wr(per_wr), .off(off), .wdata(io_core_req_wdata),
    .be(io_core_req_be), .mtime(mtime), .mtimecmp(mtimecmp), .ctrl(ctrl), .irq(io_timer_irq)
  );
  always_comb begin
    rd_val = off == OFF_GPIO     ? io_gpio_out :
             off == OFF_ERR      ? {31'b0, err_drop} :
             off == OFF_MTIME    ? mtime :
             off == OFF_MTIMECMP ? mtimecmp :
             off == OFF_CTRL     ? {29'b0, ctrl} : '0;
  end
`else
  assign mtime        = '0;
  assign mtimecmp     = '0;
  assign ctrl         = '0;
  assign io_timer_irq = 1'b0;
  always_comb begin
    rd_val = off == OFF_GPIO ? io_gpio_out :
             off == OFF_ERR  ? {31'b0, err_drop} : '0;
  end
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rdata_q     <= '0;
      io_gpio_out <= '0;
      err_drop    <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io_core_req_valid) begin
          state   <= hit ? PERIPH_RSP : WAIT_SRAM;
          wr_q    <= io_core_req_we;
          rdata_q <= (hit & ~io_core_req_we) ? rd_val : '0;
        end
        WAIT_SRAM: if (io_sram_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (per_wr && off == OFF_GPIO) io_gpio_out <= be_merge(io_gpio_out, io_core_req_wdata, io_core_req_be);
      // a drop in the same cycle as a W1C keeps the flag set
      err_drop <= drop | (err_drop & ~(per_wr && off == OFF_ERR && io_core_req_be[0] && io_core_req_wdata[0]));
    end
  end
endmodule
